instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction supplier for the 32-bit RISC-like core: the source side of the instruction interface that the core consumes.
- Holds the program counter and a word-addressed instruction memory that the bench loads through a program port.
- Streams instructions to the core over a valid/ready handshake through a 2-entry prefetch buffer.
- Accepts branch redirects from the core.

Parameters:
- AW, 8: PC / instruction-memory address width in words; memory depth = 2^AW.
- INSTR_W, 32: instruction width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- prog_we  in  1  program-memory write enable.
- prog_addr  in  AW  program-memory write address.
- prog_data  in  INSTR_W  program-memory write data.
- redirect  in  1  branch/jump taken; flush and restart fetch.
- redirect_pc  in  AW  new fetch word address.
- instr_ready  in  1  core can accept an instruction.
- instr_valid  out  1  instr / instr_pc are valid.
- instr  out  INSTR_W  instruction word.
- instr_pc  out  AW  word address of instr.
- halted  out  1  fetch stopped on a halt instruction (FETCH_HALT_EN only).

Behaviour:
- Reset (rst==0 at posedge):
  - fetch_pc=0, buffer emptied, any in-flight read discarded, state=RUN.
  - instr_valid=0, instr=0, instr_pc=0, halted=0.
  - Memory contents are kept. prog_we writes are honoured during reset.
- Memory read is synchronous: address issued in cycle N, data available in cycle N+1, tagged with its PC.
- Read issue rule: a read is issued only when (buffer count + in-flight) < 2. fetch_pc increments by 1 per issued read and wraps from 2^AW-1 to 0.
- Latency: first instr_valid=1 occurs 2 cycles after the first posedge with rst==1. With instr_ready held at 1, throughput is 1 instruction/cycle and PCs are consecutive.
- Handshake:
  - A transfer occurs on a posedge where instr_valid && instr_ready.
  - While instr_valid && !instr_ready, instr and instr_pc hold stable.
  - No instruction is dropped or duplicated; order is preserved.
  - instr_valid never deasserts without a transfer, except on redirect or reset.
- Buffer boundaries:
  - Full (2 entries) plus ready=0: no reads issued, fetch_pc frozen.
  - Empty: instr_valid=0.
  - Simultaneous pop and arriving read data: both are applied in the same cycle.
- Redirect (redirect==1 at posedge):
  - Buffer flushed, in-flight read discarded, fetch_pc=redirect_pc.
  - instr_valid=0 in the following cycle. The target instruction becomes valid 2 cycles after the redirect edge.
  - A transfer occurring on the same edge counts as consumed.
  - Reset has priority over redirect.
- prog_we and a read to the same address on the same edge: the read returns the old word.
- States: RUN (normal fetch) and HALT (macro only). Redirect acts within RUN in a single cycle; there is no separate flush state.

Optional Feature:
FETCH_HALT_EN
- Defined:
  - A word with opcode bits [31:26]==6'b111111 is delivered normally, and no reads are issued after it enters the buffer.
  - When the core accepts it, the unit enters HALT and sets halted=1.
  - In HALT, instr_valid=0. HALT exits only on redirect (clears halted, resumes at redirect_pc) or on reset.
- Undefined: the opcode is an ordinary instruction, there is no HALT state, and halted is tied to 0.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32, OPC_MSB=31, OPC_LSB=26, OPC_HALT=6'b111111.
  - Fetch state enum {RUN, HALT}.
  - Fetch-entry struct {instr, pc}.
- Sub-module fetch_skid_buf: 2-entry buffer with push/pop/flush, count output and entry output. The top level holds the PC, memory, issue logic and state.

Test Plan:
1. Load word0=0x10010002 (addi $1,$0,2), word1=0x10020003, word2=0x00221800. Release reset with ready=1. Required: instr_valid rises 2 cycles after release; (pc,instr) = (0,0x10010002), (1,0x10020003), (2,0x00221800) on consecutive cycles.
2. Backpressure: ready=0 for 5 cycles once pc0 is valid. Required: instr=0x10010002 and instr_pc=0 held; after ready=1, PCs 0,1,2 on consecutive cycles, none lost.
3. Redirect with redirect_pc=5 while pc2 is valid and ready=0. Required: next cycle instr_valid=0; 2 cycles after the edge instr_pc=5 with word5 contents.
4. AW=4, redirect to 15, ready=1. Required: delivered PCs 15, 0, 1 (wrap).
5. Drive rst=0 mid-stream with the buffer full and ready=0. Required: next cycle instr_valid=0 and halted=0; after release, fetch restarts at pc 0 and memory contents are intact.
6. FETCH_HALT_EN, word3=0xFC000000, ready=1. Required: PCs 0..3 delivered, halted=1 after pc3 is accepted, pc4 never valid; redirect to 0 clears halted. Without the macro, pc4 follows pc3.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   INSTR_W          instruction width
//   OPC_MSB/OPC_LSB  opcode field position inside an instruction word
//   OPC_HALT         opcode that stops fetch when FETCH_HALT_EN is defined
//   fetch_state_t    RUN / HALT fetch state
//   fetch_entry_t    {instr, pc} pair for the default 8-bit word address
//   is_halt()        opcode test for the halt instruction
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam logic [5:0] OPC_HALT = 6'b111111;
  localparam int DEF_AW = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DEF_AW-1:0]  pc;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] w);
    return (w[OPC_MSB:OPC_LSB] == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry in-order buffer between the instruction memory
// read stage and the core.
//   clk    clock
//   rst    synchronous active-low reset (empties buffer, clears entries)
//   flush  discard all entries (wins over push/pop)
//   push   write din behind the current entries
//   pop    remove the head entry
//   din    entry to push
//   count  number of valid entries (0..2)
//   head   oldest entry, meaningful when count != 0
// The caller guarantees pop only when count != 0 and push only when a slot
// is free after this edge's pop.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  entry_t     din,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t     ent0;
  entry_t     ent1;
  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Pop and arriving data in the same cycle: count stays put.
          if (cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= din;
          end else begin
            ent0 <= din;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = ent0;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, word-addressed instruction memory and
// prefetch issue logic feeding the core over a valid/ready handshake.
//   clk, rst                  clock; synchronous active-low reset
//   prog_we/addr/data         instruction memory write port (works in reset)
//   redirect, redirect_pc     flush the pipeline and restart fetch
//   instr_ready               core accepts the head instruction
//   instr_valid/instr/instr_pc head of the prefetch buffer
//   halted                    fetch stopped on a halt opcode
// Build option: define FETCH_HALT_EN to make opcode OPC_HALT stop fetch and
// enter the HALT state once the core accepts it; otherwise halted is 0.
module instr_fetch_unit #(
  parameter int AW      = 8,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               redirect,
  input  logic [AW-1:0]      redirect_pc,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [AW-1:0]      instr_pc,
  output logic               halted
);
  import fetch_pkg::*;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [AW-1:0]      pc;
  } entry_t;

  logic [INSTR_W-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]      fetch_pc;
  logic               fetch_en;
  logic               vld_p1;
  logic [INSTR_W-1:0] rd_data_p1;
  logic [AW-1:0]      rd_pc_p1;
  logic [1:0]         count;
  entry_t             head;
  entry_t             din;
  logic               pop;
  logic               push;
  logic               issue;
  logic               hold_fetch;
  logic [2:0]         occ;

  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign pop         = instr_valid && instr_ready;
  assign push        = vld_p1 && !redirect;
  assign din         = '{instr: rd_data_p1, pc: rd_pc_p1};

  // Occupancy seen by the issue decision: a pop on this edge frees its slot,
  // so a steady ready=1 stream sustains one read per cycle.
  assign occ = {1'b0, count} - {2'b00, pop} + {2'b00, vld_p1};

`ifdef FETCH_HALT_EN
  fetch_state_t state;
  logic         halt_pend;
  logic         halt_arrive;
  logic         halt_take;

  // Block issue on the very edge the halt word lands in the buffer, so no
  // younger read is ever started behind it.
  assign halt_arrive = vld_p1 && is_halt(rd_data_p1);
  assign halt_take   = pop && is_halt(head.instr);
  assign hold_fetch  = halt_pend || halt_arrive || (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      halted    <= 1'b0;
      halt_pend <= 1'b0;
    end else if (redirect) begin
      state     <= RUN;
      halted    <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      if (halt_arrive) halt_pend <= 1'b1;
      if ((state == RUN) && halt_take) begin
        state     <= HALT;
        halted    <= 1'b1;
        halt_pend <= 1'b0;
      end
    end
  end
`else
  assign hold_fetch = 1'b0;
  assign halted     = 1'b0;
`endif

  assign issue = fetch_en && !redirect && !hold_fetch && (occ < 3'd2);

  // The first edge out of reset only arms fetch, mirroring a redirect edge:
  // both start reading on the following edge, giving a 2-cycle start-up.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= '0;
      fetch_en <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      fetch_en <= 1'b1;
      vld_p1   <= issue;
      if (redirect)   fetch_pc <= redirect_pc;
      else if (issue) fetch_pc <= fetch_pc + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // ---- stage p0 -> p1: synchronous memory read, tagged with its PC ----
  // A write to the same address on the same edge returns the old word.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data_p1 <= mem[fetch_pc];
      rd_pc_p1   <= fetch_pc;
    end
  end

  // ---- stage p1 -> buffer: read data enters the prefetch buffer ----
  fetch_skid_buf #(
    .entry_t(entry_t)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect),
    .push (push),
    .pop  (pop),
    .din  (din),
    .count(count),
    .head (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] W0    = 32'h10010002;
  localparam logic [31:0] W1    = 32'h10020003;
  localparam logic [31:0] W2    = 32'h00221800;
  localparam logic [31:0] WHALT = 32'hFC000000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_ready = 1'b0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          halted;

  logic [31:0] mmem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.AW(AW), .INSTR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'b111111) w[31] = 1'b0;
    return w;
  endfunction

  task automatic load(input int a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    mmem[a]   = d;
  endtask

  // Reset for two edges, release; returns when pc0 has just become valid.
  task automatic restart(input logic rdy);
    rst = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b1; instr_ready = rdy;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      if (a == 0)      load(a, W0);
      else if (a == 1) load(a, W1);
      else if (a == 2) load(a, W2);
      else             load(a, rand_word());
    end
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    n_tests++;
    if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h want=0", instr); end
    n_tests++;
    if (instr_pc !== '0) begin n_fail++; $display("FAIL reset_pc got=%0d want=0", instr_pc); end
    n_tests++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b want=0", halted); end
  endtask

  task automatic test_startup();
    instr_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL startup_latency edge=%0d valid=%b want=0", i, instr_valid);
      end
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(k) || instr !== mmem[k]) begin
        n_fail++;
        $display("FAIL startup_stream v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                 instr_valid, instr_pc, instr, k, mmem[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    restart(1'b0);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== '0 || instr !== W0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d v=%b pc=%0d instr=%h want v=1 pc=0 instr=%h",
                 i, instr_valid, instr_pc, instr, W0);
      end
      tick();
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(k) || instr !== mmem[k]) begin
        n_fail++;
        $display("FAIL bp_release v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                 instr_valid, instr_pc, instr, k, mmem[k]);
      end
      if (k < 2) tick();
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = AW'(5);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL redir_bubble cyc=%0d valid=%b want=0", i, instr_valid);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(5) || instr !== mmem[5]) begin
        n_fail++;
        $display("FAIL redir_target v=%b pc=%0d instr=%h want v=1 pc=5 instr=%h",
                 instr_valid, instr_pc, instr, mmem[5]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int exp_pc;
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = AW'(DEPTH - 1);
    tick();
    redirect = 1'b0;
    tick(); tick();
    exp_pc = DEPTH - 1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(exp_pc) || instr !== mmem[exp_pc]) begin
        n_fail++;
        $display("FAIL wrap v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                 instr_valid, instr_pc, instr, exp_pc, mmem[exp_pc]);
      end
      exp_pc = (exp_pc + 1) % DEPTH;
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    instr_ready = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill valid=%b want=1", instr_valid); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (instr_valid !== 1'b0 || halted !== 1'b0 || instr_pc !== '0 || instr !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset v=%b halted=%b pc=%0d instr=%h want all zero",
               instr_valid, halted, instr_pc, instr);
    end
    rst = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_latency valid=%b want=0", instr_valid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(k) || instr !== mmem[k]) begin
        n_fail++;
        $display("FAIL mid_restart v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                 instr_valid, instr_pc, instr, k, mmem[k]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    tick();
    load(3, WHALT);
    rst = 1'b1; instr_ready = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(k) || instr !== mmem[k]) begin
        n_fail++;
        $display("FAIL halt_stream v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                 instr_valid, instr_pc, instr, k, mmem[k]);
      end
      tick();
    end
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (instr_valid !== 1'b0 || halted !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_state cyc=%0d v=%b halted=%b pc=%0d want v=0 halted=1",
                 i, instr_valid, halted, instr_pc);
      end
      tick();
    end
    redirect = 1'b1; redirect_pc = '0;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear halted=%b want=0", halted); end
    tick(); tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== '0 || instr !== W0) begin
      n_fail++;
      $display("FAIL halt_resume v=%b pc=%0d instr=%h want v=1 pc=0 instr=%h",
               instr_valid, instr_pc, instr, W0);
    end
`else
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== AW'(4) || instr !== mmem[4] || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL nohalt_follow v=%b pc=%0d instr=%h halted=%b want v=1 pc=4 instr=%h halted=0",
               instr_valid, instr_pc, instr, halted, mmem[4]);
    end
`endif
    rst = 1'b0; instr_ready = 1'b0;
    tick();
    load(3, rand_word());
  endtask

  task automatic test_random();
    int   exp_pc;
    int   since_redir;
    int   ready_run;
    logic prev_valid;
    logic prev_ready;
    restart(1'b1);
    exp_pc = 0; since_redir = 3; ready_run = 0;
    prev_valid = 1'b0; prev_ready = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (since_redir == 1 || since_redir == 2) begin
        n_tests++;
        if (instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL rnd_redir_bubble cyc=%0d valid=%b want=0", c, instr_valid);
        end
      end
      if (since_redir == 3) begin
        n_tests++;
        if (instr_valid !== 1'b1) begin
          n_fail++; $display("FAIL rnd_redir_latency cyc=%0d valid=%b want=1", c, instr_valid);
        end
      end
      if (prev_valid && !prev_ready && since_redir != 1) begin
        n_tests++;
        if (instr_valid !== 1'b1) begin
          n_fail++; $display("FAIL rnd_valid_drop cyc=%0d valid=%b want=1", c, instr_valid);
        end
      end
      if (ready_run >= 4) begin
        n_tests++;
        if (instr_valid !== 1'b1) begin
          n_fail++; $display("FAIL rnd_throughput cyc=%0d valid=%b want=1", c, instr_valid);
        end
      end
      if (instr_valid === 1'b1) begin
        n_tests++;
        if (instr_pc !== AW'(exp_pc) || instr !== mmem[exp_pc]) begin
          n_fail++;
          $display("FAIL rnd_order cyc=%0d pc=%0d instr=%h want pc=%0d instr=%h",
                   c, instr_pc, instr, exp_pc, mmem[exp_pc]);
        end
      end
      redirect    = (since_redir >= 3) && ($urandom_range(0, 19) == 0);
      redirect_pc = AW'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      if (instr_valid === 1'b1 && instr_ready) exp_pc = (exp_pc + 1) % DEPTH;
      if (redirect) begin
        exp_pc = int'(redirect_pc);
        since_redir = 0;
      end
      ready_run  = (instr_ready && !redirect) ? ready_run + 1 : 0;
      prev_valid = instr_valid;
      prev_ready = instr_ready;
      tick();
      if (since_redir < 100) since_redir++;
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
